// File: rtl/uart_receiver.sv
// uart_receiver: rebuilds a PACKET_SIZE-bit word from the transmitter's LSB-first
// serial stream, starting on the rising edge of sendSig and sampling mid-bit.
// Optional feature macro: RX_SYNC_EN (2-flop input synchronizers, +2 cycle timing).
module uart_receiver #(
    parameter int PACKET_SIZE = 16,
    parameter int CYCLE_DIV   = 100,
    parameter int PROP_DELAY  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sendSig,
    input  logic                   bsIn,
    output logic [PACKET_SIZE-1:0] dataOut,
    output logic                   dataValid,
    output logic                   busy
);

    // Cycles from the edge to the middle of data bit 0.
    localparam int WAIT_CYC = (1 + PROP_DELAY) * CYCLE_DIV + CYCLE_DIV / 2;
    localparam int CNT_W    = $clog2(CYCLE_DIV * (PROP_DELAY + 2));
    localparam int IDX_W    = $clog2(PACKET_SIZE + 1);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLE_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PACKET_SIZE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} stateType;

    stateType               state, nextState;
    logic                   sendSigUse, bsInUse;
    logic                   sendSigD;
    logic                   sampleNow;
    logic [CNT_W-1:0]       cycleCnt;
    logic [IDX_W-1:0]       bitIdx;
    // Holds the first PACKET_SIZE-1 samples; the last sample goes straight to dataOut.
    logic [PACKET_SIZE-2:0] shiftReg;

`ifdef RX_SYNC_EN
    logic [1:0] sendSync, bsSync;

    // Two-flop synchronizers for a transmitter in another clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sendSync <= '0;
            bsSync   <= '0;
        end else begin
            sendSync <= {sendSync[0], sendSig};
            bsSync   <= {bsSync[0], bsIn};
        end
    end

    assign sendSigUse = sendSync[1];
    assign bsInUse    = bsSync[1];
`else
    // Same-clock loopback: pins are used directly.
    assign sendSigUse = sendSig;
    assign bsInUse    = bsIn;
`endif

    // Edge register; resets high so a strobe already up at release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) sendSigD <= 1'b1;
        else       sendSigD <= sendSigUse;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state and outputs; edges are only honoured in IDLE.
    always_comb begin
        nextState = state;
        sampleNow = 1'b0;
        dataValid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (sendSigUse && !sendSigD) nextState = WAIT;
            end
            WAIT: begin
                if (cycleCnt == WAIT_LAST) begin
                    sampleNow = 1'b1;
                    nextState = (bitIdx == IDX_LAST) ? DONE : SAMPLE;
                end
            end
            SAMPLE: begin
                if (cycleCnt == BIT_LAST) begin
                    sampleNow = 1'b1;
                    if (bitIdx == IDX_LAST) nextState = DONE;
                end
            end
            DONE: begin
                dataValid = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Counters and shifter. dataOut is loaded on the last sample so it is
    // already stable during the DONE cycle that raises dataValid.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCnt <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            dataOut  <= '0;
        end else if (state == IDLE) begin
            cycleCnt <= '0;
            bitIdx   <= '0;
        end else if (sampleNow) begin
            cycleCnt <= '0;
            bitIdx   <= bitIdx + IDX_W'(1);
            shiftReg <= {bsInUse, shiftReg[PACKET_SIZE-2:1]};
            if (bitIdx == IDX_LAST) dataOut <= {bsInUse, shiftReg};
        end else begin
            cycleCnt <= cycleCnt + CNT_W'(1);
        end
    end

endmodule
